// File: rtl/drp_multi_master.sv
// drp_multi_master: serialises read / write / read-modify-write requests from a
// single valid/ready request port onto one of NUM_CH DRP ports, with a
// per-access drprdy timeout and a one-cycle response strobe.
//
// Ports:
//   drp_clk, rst        clock and synchronous active-high reset
//   req_valid/req_ready request handshake
//   req_op/ch/addr/wdata/mask  request payload (op 00 rd, 01 wr, 10 rmw)
//   rsp_valid/rsp_rdata/rsp_err one-cycle response (err 00 ok, 01 timeout, 10 bad)
//   busy_o              access in progress
//   drpen_o/drpwe_o     per-channel DRP strobes
//   drpaddr_o/drpdi_o   shared DRP address / write data
//   drpdo_i/drprdy_i    per-channel DRP read data / ready
module drp_multi_master #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     drp_clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [CH_W-1:0]          req_ch,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic [DATA_W-1:0]        req_mask,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [1:0]               rsp_err,
    output logic                     busy_o,
    output logic [NUM_CH-1:0]        drpen_o,
    output logic [NUM_CH-1:0]        drpwe_o,
    output logic [ADDR_W-1:0]        drpaddr_o,
    output logic [DATA_W-1:0]        drpdi_o,
    input  logic [NUM_CH*DATA_W-1:0] drpdo_i,
    input  logic [NUM_CH-1:0]        drprdy_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RMW = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_TMO = 2'b01;
    localparam logic [1:0] ERR_BAD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_EN,
        S_RD_WAIT,
        S_WR_EN,
        S_WR_WAIT,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_err_q, rsp_err_d;
    logic                busy_q, busy_d;
    logic [NUM_CH-1:0]   drpen_q, drpen_d;
    logic [NUM_CH-1:0]   drpwe_q, drpwe_d;
    logic [ADDR_W-1:0]   drpaddr_q, drpaddr_d;
    logic [DATA_W-1:0]   drpdi_q, drpdi_d;

    logic                rdy_sel_c;
    logic [DATA_W-1:0]   rdo_sel_c;
    logic                req_bad_c;

    // One-hot channel decode; channels beyond NUM_CH decode to all zeros.
    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch == CH_W'(k)) begin
                v[k] = 1'b1;
            end
        end
        return v;
    endfunction

    // Only the addressed channel's ready and read data are looked at.
    always_comb begin
        rdy_sel_c = 1'b0;
        rdo_sel_c = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) begin
                rdy_sel_c = drprdy_i[k];
                rdo_sel_c = drpdo_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign req_bad_c = (32'(req_ch) >= NUM_CH) || (req_op == OP_RSV);

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ch_d        = ch_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        drpaddr_d   = drpaddr_q;
        drpdi_d     = drpdi_q;
        drpen_d     = '0;
        drpwe_d     = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d    = req_op;
                    ch_d    = req_ch;
                    wdata_d = req_wdata;
                    mask_d  = req_mask;
                    rdata_d = '0;
                    if (req_bad_c) begin
                        state_d     = S_RESP;
                        rsp_rdata_d = '0;
                        rsp_err_d   = ERR_BAD;
                    end else begin
                        drpaddr_d = req_addr;
                        drpdi_d   = req_wdata;
                        drpen_d   = ch_onehot(req_ch);
                        if (req_op == OP_WR) begin
                            drpwe_d = ch_onehot(req_ch);
                            state_d = S_WR_EN;
                        end else begin
                            state_d = S_RD_EN;
                        end
                    end
                end
            end

            S_RD_EN: begin
                cnt_d   = '0;
                state_d = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                if (rdy_sel_c) begin
                    rdata_d = rdo_sel_c;
                    if (op_q == OP_RMW) begin
                        // Merge: masked bits from the request, the rest keep the old value.
                        drpdi_d = (rdo_sel_c & ~mask_q) | (wdata_q & mask_q);
                        drpen_d = ch_onehot(ch_q);
                        drpwe_d = ch_onehot(ch_q);
                        state_d = S_WR_EN;
                    end else begin
                        rsp_rdata_d = rdo_sel_c;
                        rsp_err_d   = ERR_OK;
                        state_d     = S_RESP;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = ERR_TMO;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WR_EN: begin
                cnt_d   = '0;
                state_d = S_WR_WAIT;
            end

            S_WR_WAIT: begin
                if (rdy_sel_c) begin
                    rsp_rdata_d = (op_q == OP_RMW) ? rdata_q : '0;
                    rsp_err_d   = ERR_OK;
                    state_d     = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = ERR_TMO;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    // State and output registers.
    always_ff @(posedge drp_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_RD;
            ch_q        <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
            busy_q      <= 1'b0;
            drpen_q     <= '0;
            drpwe_q     <= '0;
            drpaddr_q   <= '0;
            drpdi_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ch_q        <= ch_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            drpen_q     <= drpen_d;
            drpwe_q     <= drpwe_d;
            drpaddr_q   <= drpaddr_d;
            drpdi_q     <= drpdi_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy_o    = busy_q;
    assign drpen_o   = drpen_q;
    assign drpwe_o   = drpwe_q;
    assign drpaddr_o = drpaddr_q;
    assign drpdi_o   = drpdi_q;

endmodule

// File: tb/tb_drp_multi_master.sv
// Bench for drp_multi_master: behavioural DRP slaves per channel, a response
// scoreboard and a strobe log checked after each transaction.
module tb_drp_multi_master;

    localparam int unsigned NCH = 3;
    localparam int unsigned AW  = 9;
    localparam int unsigned DW  = 16;
    localparam int unsigned TMO = 8;

    typedef struct {
        logic [DW-1:0] rdata;
        logic [1:0]    err;
    } exp_t;

    typedef struct {
        logic [NCH-1:0] en;
        logic [NCH-1:0] we;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  di;
        int             cyc;
    } strobe_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [1:0]         req_op = 2'b00;
    logic [1:0]         req_ch = 2'b00;
    logic [AW-1:0]      req_addr = '0;
    logic [DW-1:0]      req_wdata = '0;
    logic [DW-1:0]      req_mask = '0;
    logic               rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic [1:0]         rsp_err;
    logic               busy;
    logic [NCH-1:0]     drpen;
    logic [NCH-1:0]     drpwe;
    logic [AW-1:0]      drpaddr;
    logic [DW-1:0]      drpdi;
    logic [NCH*DW-1:0]  drpdo = '0;
    logic [NCH-1:0]     drprdy = '0;

    logic [DW-1:0] mem [NCH][512];
    int            lat [NCH];
    int            wcnt [NCH];
    logic [DW-1:0] rdval [NCH];
    logic [NCH-1:0] spur = '0;

    exp_t    exp_q[$];
    strobe_t strobe_q[$];

    int cyc = 0;
    int rdy_cyc = 0;
    int rsp_cyc = 0;
    int en_cyc = 0;
    int acc_cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    drp_multi_master #(
        .NUM_CH (NCH),
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TMO)
    ) dut (
        .drp_clk  (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_ch   (req_ch),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_mask (req_mask),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy_o   (busy),
        .drpen_o  (drpen),
        .drpwe_o  (drpwe),
        .drpaddr_o(drpaddr),
        .drpdi_o  (drpdi),
        .drpdo_i  (drpdo),
        .drprdy_i (drprdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // DRP slave models: capture on drpen, answer drprdy lat[k] cycles later (0 = never).
    always @(negedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            drprdy[k] = spur[k];
            if (spur[k]) drpdo[k*DW +: DW] = 16'hDEAD;
            if (wcnt[k] > 0) begin
                wcnt[k]--;
                if (wcnt[k] == 0) begin
                    drprdy[k]          = 1'b1;
                    drpdo[k*DW +: DW]  = rdval[k];
                    rdy_cyc            = cyc;
                end
            end
            if (drpen[k]) begin
                rdval[k] = drpwe[k] ? 16'h0000 : mem[k][drpaddr];
                if (drpwe[k]) mem[k][drpaddr] = drpdi;
                wcnt[k] = lat[k];
            end
        end
    end

    // Strobe log and response scoreboard.
    always @(negedge clk) begin
        if (drpen != '0) begin
            strobe_q.push_back('{drpen, drpwe, drpaddr, drpdi, cyc});
            en_cyc = cyc;
        end
        if (rsp_valid) begin
            rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [1:0] ch, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] mk,
                        input logic [DW-1:0] er, input logic [1:0] ee, input bit push);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_ready_wait", 32'(req_ready), 32'd1);
        req_op    = op;
        req_ch    = ch;
        req_addr  = addr;
        req_wdata = wd;
        req_mask  = mk;
        req_valid = 1'b1;
        acc_cyc   = cyc;
        if (push) exp_q.push_back('{er, ee});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_eq("rsp_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_strobe(input string tag, input int idx, input logic [NCH-1:0] en,
                                input logic [NCH-1:0] we, input logic [AW-1:0] addr);
        if (strobe_q.size() > idx) begin
            check_eq({tag, "_en"}, 32'(strobe_q[idx].en), 32'(en));
            check_eq({tag, "_we"}, 32'(strobe_q[idx].we), 32'(we));
            check_eq({tag, "_addr"}, 32'(strobe_q[idx].addr), 32'(addr));
        end else begin
            check_eq({tag, "_missing"}, 32'(strobe_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NCH; k++) begin
            for (int a = 0; a < 512; a++) mem[k][a] = 16'h0000;
            wcnt[k]  = 0;
            rdval[k] = 16'h0000;
        end
        mem[2][9'h05C] = 16'hBEEF;
        mem[1][9'h010] = 16'hFF00;
        mem[0][9'h030] = 16'hABCD;
        lat[0] = 2;
        lat[1] = 1;
        lat[2] = 3;

        // Reset behaviour.
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        check_eq("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_rst_drpen", 32'(drpen), 32'd0);
        check_eq("post_rst_drpwe", 32'(drpwe), 32'd0);
        check_eq("post_rst_drpaddr", 32'(drpaddr), 32'd0);
        check_eq("post_rst_drpdi", 32'(drpdi), 32'd0);
        check_eq("post_rst_rdata", 32'(rsp_rdata), 32'd0);
        check_eq("post_rst_err", 32'(rsp_err), 32'd0);

        // Read ch2, 3-cycle slave latency.
        strobe_q.delete();
        send(2'b00, 2'd2, 9'h05C, 16'h0000, 16'h0000, 16'hBEEF, 2'b00, 1'b1);
        check_eq("rd_busy", 32'(busy), 32'd1);
        wait_rsp();
        check_eq("rd_n_strobe", 32'(strobe_q.size()), 32'd1);
        check_strobe("rd", 0, 3'b100, 3'b000, 9'h05C);
        if (strobe_q.size() > 0)
            check_eq("rd_en_latency", 32'(strobe_q[0].cyc - acc_cyc), 32'd1);
        check_eq("rd_rsp_latency", 32'(rsp_cyc - rdy_cyc), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("rd_hold", 32'(rsp_rdata), 32'h0000BEEF);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Write ch0.
        strobe_q.delete();
        send(2'b01, 2'd0, 9'h1FF, 16'h1234, 16'h0000, 16'h0000, 2'b00, 1'b1);
        wait_rsp();
        check_eq("wr_n_strobe", 32'(strobe_q.size()), 32'd1);
        check_strobe("wr", 0, 3'b001, 3'b001, 9'h1FF);
        if (strobe_q.size() > 0)
            check_eq("wr_di", 32'(strobe_q[0].di), 32'h1234);
        check_eq("wr_mem", 32'(mem[0][9'h1FF]), 32'h1234);

        // Read-modify-write ch1.
        strobe_q.delete();
        send(2'b10, 2'd1, 9'h010, 16'h00AA, 16'h00F0, 16'hFF00, 2'b00, 1'b1);
        wait_rsp();
        check_eq("rmw_n_strobe", 32'(strobe_q.size()), 32'd2);
        check_strobe("rmw_rd", 0, 3'b010, 3'b000, 9'h010);
        check_strobe("rmw_wr", 1, 3'b010, 3'b010, 9'h010);
        if (strobe_q.size() > 1)
            check_eq("rmw_di", 32'(strobe_q[1].di), 32'hFFA0);
        check_eq("rmw_mem", 32'(mem[1][9'h010]), 32'hFFA0);

        // Timeout on a read (slave never answers).
        lat[2] = 0;
        strobe_q.delete();
        send(2'b00, 2'd2, 9'h020, 16'h0000, 16'h0000, 16'h0000, 2'b01, 1'b1);
        wait_rsp();
        check_eq("tmo_n_strobe", 32'(strobe_q.size()), 32'd1);
        check_eq("tmo_latency", 32'(rsp_cyc - en_cyc), 32'(TMO + 2));

        // Timeout on an RMW: the write phase must not happen.
        strobe_q.delete();
        send(2'b10, 2'd2, 9'h05C, 16'h1111, 16'hFFFF, 16'h0000, 2'b01, 1'b1);
        wait_rsp();
        check_eq("tmo_rmw_n_strobe", 32'(strobe_q.size()), 32'd1);
        check_strobe("tmo_rmw", 0, 3'b100, 3'b000, 9'h05C);
        check_eq("tmo_rmw_mem", 32'(mem[2][9'h05C]), 32'hBEEF);
        lat[2] = 3;

        // Bad channel and reserved op.
        strobe_q.delete();
        send(2'b00, 2'd3, 9'h005, 16'h0000, 16'h0000, 16'h0000, 2'b10, 1'b1);
        wait_rsp();
        send(2'b11, 2'd0, 9'h005, 16'h5555, 16'h0000, 16'h0000, 2'b10, 1'b1);
        wait_rsp();
        check_eq("bad_n_strobe", 32'(strobe_q.size()), 32'd0);

        // Spurious ready pulses: while idle, then on non-target channels mid-access.
        spur = 3'b111;
        repeat (2) @(negedge clk);
        spur = 3'b000;
        @(negedge clk);
        check_eq("spur_idle_busy", 32'(busy), 32'd0);
        lat[0] = 4;
        strobe_q.delete();
        send(2'b00, 2'd0, 9'h030, 16'h0000, 16'h0000, 16'hABCD, 2'b00, 1'b1);
        spur = 3'b110;
        repeat (2) @(negedge clk);
        spur = 3'b000;
        wait_rsp();
        check_eq("spur_rsp_latency", 32'(rsp_cyc - rdy_cyc), 32'd1);
        lat[0] = 2;

        // Reset during RD_WAIT abandons the access silently.
        lat[1] = 0;
        send(2'b00, 2'd1, 9'h044, 16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_drpen", 32'(drpen), 32'd0);
        check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
        check_eq("mid_rst_drpaddr", 32'(drpaddr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_post_req_ready", 32'(req_ready), 32'd1);
        lat[1] = 1;
        repeat (3) @(negedge clk);
        strobe_q.delete();
        send(2'b00, 2'd1, 9'h010, 16'h0000, 16'h0000, 16'hFFA0, 2'b00, 1'b1);
        wait_rsp();
        check_eq("after_rst_n_strobe", 32'(strobe_q.size()), 32'd1);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
